lan_spi_master: RTL and testbench
=================================

// Module: lan_spi_master
// PURPOSE
//  Hardware SPI byte engine between the CPU-side command logic and the external LAN
//  controller SPI pins (MOSI/SCLK/SS_n/MISO).
//  Accepts bytes over a valid/ready stream and frames multi-byte transactions under one SS_n.
//  Returns each received MISO byte on a one-cycle strobe.
//  Synchronises the controller's active-low interrupt line (NINT) into the clk domain.
// PARAMETERS
//  CLK_DIV   4  clk cycles per SCLK half-period (>=1); SCLK period = 2*CLK_DIV clk
//  CS_SETUP  2  clk cycles SS_n low before first SCLK edge (>=1)
//  CS_HOLD   2  clk cycles after last SCLK fall before SS_n rises (>=1)
//  CS_GAP    4  minimum clk cycles SS_n high between transactions (>=1)
// PORTS
//  clk          in   1  system clock, all logic rising-edge
//  reset_n      in   1  asynchronous active-low reset
//  tx_data      in   8  byte to transmit, MSB first
//  tx_last      in   1  qualifies tx_data: final byte of transaction
//  tx_valid     in   1  tx_data/tx_last valid
//  tx_ready     out  1  byte accepted when tx_valid && tx_ready
//  rx_data      out  8  byte shifted in from MISO; held until next rx_valid
//  rx_valid     out  1  one-cycle pulse, rx_data updated
//  busy         out  1  high whenever state != IDLE
//  MISO         in   1  serial data from LAN controller
//  MOSI         out  1  serial data to LAN controller
//  SCLK         out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
//  SS_n         out  1  active-low chip select
//  nint         in   1  LAN interrupt, active-low, asynchronous
//  irq          out  1  active-high level: nint through 2-flop synchroniser, inverted
// BEHAVIOUR
//  Reset: SS_n=1, SCLK=0, MOSI=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, irq=0.
//  State -> IDLE immediately; any byte in flight is discarded.
//  tx_ready rises on the first clk after reset release.
//  States:
//   IDLE: tx_ready=1. On accept, latch byte+last; SS_n->0; MOSI=bit7; go SETUP.
//   SETUP: count CS_SETUP cycles; go SHIFT.
//   SHIFT: 16 half-periods of CLK_DIV cycles each; SCLK toggles at each half-period end.
//    SCLK rise: sample MISO into shift register LSB.
//    SCLK fall (not the 8th): MOSI <- next bit.
//    After the 8th fall: SCLK=0; rx_valid=1 for 1 cycle with the assembled byte.
//    Then go HOLD if last, else WAIT.
//   WAIT: SS_n stays 0, SCLK=0, tx_ready=1; MOSI holds the final bit.
//    On accept, latch byte+last; MOSI=bit7.
//    Go SHIFT after one setup half-period (CLK_DIV cycles).
//    Stalls indefinitely while tx_valid=0.
//   HOLD: CS_HOLD cycles; SS_n->1; go GAP.
//   GAP: CS_GAP cycles with SS_n=1; go IDLE.
//  tx_ready=0 in SETUP/SHIFT/HOLD/GAP; tx_valid there is ignored, not lost (stream stalls).
//  Latency IDLE accept -> rx_valid = CS_SETUP + 16*CLK_DIV + 1 clk.
//  Latency WAIT accept -> rx_valid = 17*CLK_DIV + 1 clk.
//  Single-byte transaction (tx_last on first byte) is legal.
//  SS_n never glitches high between bytes of one transaction.
//  Counters sized for parameters; no wrap within a state.
//  irq = ~sync2(nint); 2-cycle latency from any nint change.
// TESTING
//  CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, CS_GAP=4, MISO looped to MOSI.
//   Send 0xA5, tx_last=1.
//   -> 8 SCLK pulses, period 4 clk; MOSI pattern 10100101.
//   -> rx_valid at cycle 2+32+1 after accept, rx_data=0xA5.
//   -> SS_n high 2 clk after last SCLK fall.
//  Send 0x0E,0x00,0xFF back-to-back, last on 0xFF; MISO driven 0x5A each byte.
//   -> SS_n low continuously; 3 rx_valid pulses, each 0x5A.
//  Drop tx_valid for 20 cycles after byte 1 of 2 (WAIT).
//   -> SCLK=0, SS_n=0, tx_ready=1 throughout.
//   -> Byte 2 then completes normally.
//  Assert reset_n=0 after the 4th SCLK rise.
//   -> Same cycle: SS_n=1, SCLK=0, MOSI=0, busy=0; no rx_valid.
//   -> After release, new byte 0x3C works.
//  Drive nint 1->0->1 (10 cycles low).
//   -> irq high 2 cycles after fall, low 2 cycles after rise.
//   -> Independent of an ongoing transfer.
//  Hold tx_valid=1 during GAP -> tx_ready=0 until IDLE; SS_n high >= 4 clk between transactions.

Source files
------------

// File: rtl/lan_spi_master.sv
// SPI mode-0 byte engine for the LAN controller: frames multi-byte transactions under one SS_n,
// returns each received byte on a one-cycle strobe and synchronises the NINT interrupt line.
module lan_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCLK,
  output logic       SS_n,
  input  logic       nint,
  output logic       irq
);

  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, LEAD, HOLD, GAP} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_last;
  logic [3:0]         half;
  logic [7:0]         sh;
  logic               last_q;
  logic               rx_pend;
  logic               nint_meta, nint_sync;
  logic               accept, cnt_done, tick, last_half;

  assign accept    = tx_valid & tx_ready;
  assign cnt_done  = (cnt == cnt_last);
  assign tick      = (state == SHIFT) & cnt_done;
  assign last_half = (half == 4'd15);
  assign busy      = (state != IDLE);
  assign irq       = ~nint_sync;

  // Terminal count of the per-state cycle counter; LEAD is the one-half-period setup between bytes.
  always_comb begin
    cnt_last = '0;
    case (state)
      SETUP:       cnt_last = CNT_W'(CS_SETUP - 1);
      SHIFT, LEAD: cnt_last = CNT_W'(CLK_DIV - 1);
      HOLD:        cnt_last = CNT_W'(CS_HOLD - 1);
      GAP:         cnt_last = CNT_W'(CS_GAP - 1);
      default:     cnt_last = '0;
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   if (cnt_done) state_nx = SHIFT;
      SHIFT:   if (cnt_done && last_half) state_nx = last_q ? HOLD : WAIT;
      WAIT:    if (accept) state_nx = LEAD;
      LEAD:    if (cnt_done) state_nx = SHIFT;
      HOLD:    if (cnt_done) state_nx = GAP;
      GAP:     if (cnt_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // tx_ready and SS_n are registered from the next state so they move on the same edge as the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      half     <= '0;
      sh       <= '0;
      last_q   <= 1'b0;
      rx_pend  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      MOSI     <= 1'b0;
      SCLK     <= 1'b0;
      SS_n     <= 1'b1;
      tx_ready <= 1'b0;
    end else begin
      cnt      <= (state_nx != state || cnt_done) ? '0 : cnt + 1'b1;
      tx_ready <= (state_nx == IDLE) || (state_nx == WAIT);
      SS_n     <= (state_nx == IDLE) || (state_nx == GAP);
      rx_pend  <= tick & last_half;
      rx_valid <= rx_pend;
      if (rx_pend) rx_data <= sh;

      if (state != SHIFT) half <= '0;
      else if (tick)      half <= half + 4'd1;

      if (tick) SCLK <= ~SCLK;

      // One register serves both directions: MISO enters at the LSB on rises, MOSI reads the MSB on falls.
      if (accept) begin
        sh     <= tx_data;
        last_q <= tx_last;
        MOSI   <= tx_data[7];
      end else if (tick) begin
        if (!half[0])        sh   <= {sh[6:0], MISO};
        else if (!last_half) MOSI <= sh[7];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nint_meta <= 1'b1;
      nint_sync <= 1'b1;
    end else begin
      nint_meta <= nint;
      nint_sync <= nint_meta;
    end
  end

endmodule

// File: tb/tb_lan_spi_master.sv
// Self-checking bench for lan_spi_master: scoreboarded rx bytes with exact arrival times,
// SCLK/SS_n timing monitors and one task per scenario.
module tb_lan_spi_master;

  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
  localparam int T        = 10;
  localparam int LAT_IDLE = CS_SETUP + 16 * CLK_DIV + 1;
  localparam int LAT_WAIT = 17 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       MISO;
  logic       MOSI;
  logic       SCLK;
  logic       SS_n;
  logic       nint;
  logic       irq;

  logic       miso_loop = 1'b1;
  logic [7:0] miso_pat  = 8'h00;
  logic [2:0] bit_idx   = 3'd0;

  int checks   = 0;
  int failures = 0;
  int rx_seen  = 0;

  typedef struct {
    logic [7:0] data;
    time        t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int         rise_cnt;
  int         ss_rise_cnt;
  logic [7:0] mosi_bits;
  time        last_rise_t, last_fall_t, ss_rise_t, ss_fall_t, per, per_min, per_max;

  assign MISO = miso_loop ? MOSI : miso_pat[~bit_idx];

  lan_spi_master #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx_data (tx_data),
    .tx_last (tx_last),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .MISO    (MISO),
    .MOSI    (MOSI),
    .SCLK    (SCLK),
    .SS_n    (SS_n),
    .nint    (nint),
    .irq     (irq)
  );

  always #(T / 2) clk = ~clk;

  // Scoreboard consumer: every strobe must match the oldest expected byte and its exact time.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected: got data=%h at t=%0t, no byte expected", rx_data, $time);
      end else begin
        mon_e = sb.pop_front();
        rx_seen++;
        if (rx_data !== mon_e.data || $time != mon_e.t) begin
          failures++;
          $display("FAIL rx_byte: got %h at t=%0t, required %h at t=%0t",
                   rx_data, $time, mon_e.data, mon_e.t);
        end
      end
    end
  end

  always @(posedge SCLK) begin
    mosi_bits = {mosi_bits[6:0], MOSI};
    bit_idx   = bit_idx + 3'd1;
    rise_cnt++;
    if (rise_cnt > 1) begin
      per = $time - last_rise_t;
      if (per < per_min) per_min = per;
      if (per > per_max) per_max = per;
    end
    last_rise_t = $time;
  end

  always @(negedge SCLK) last_fall_t = $time;

  always @(posedge SS_n) begin
    ss_rise_t = $time;
    ss_rise_cnt++;
  end

  always @(negedge SS_n) ss_fall_t = $time;

  task automatic clear_mon();
    rise_cnt    = 0;
    ss_rise_cnt = 0;
    bit_idx     = 3'd0;
    mosi_bits   = 8'h00;
    per_min     = 64'd1000000;
    per_max     = 64'd0;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] exp_data,
                      input int lat, input bit expect_rx);
    int   n;
    exp_t e;
    @(posedge clk);
    #1;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
    end
    @(posedge clk);
    if (expect_rx) begin
      e.data = exp_data;
      e.t    = $time + lat * T + T / 2;
      sb.push_back(e);
    end
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic test_reset();
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    tx_valid = 1'b0;
    nint     = 1'b1;
    reset_n  = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({SS_n, SCLK, MOSI, tx_ready, rx_valid, busy, irq, rx_data} !== {7'b1000000, 8'h00}) begin
      failures++;
      $display("FAIL reset_state: got ss_n/sclk/mosi/ready/rxv/busy/irq/rxd=%b_%h required 1000000_00",
               {SS_n, SCLK, MOSI, tx_ready, rx_valid, busy, irq}, rx_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got tx_ready=%b busy=%b required 1 0", tx_ready, busy);
    end
  endtask

  task automatic test_single();
    clear_mon();
    miso_loop = 1'b1;
    send(8'hA5, 1'b1, 8'hA5, LAT_IDLE, 1'b1);
    wait_idle("single");
    checks++;
    if (mosi_bits !== 8'hA5) begin
      failures++;
      $display("FAIL single_mosi: got %b required 10100101", mosi_bits);
    end
    checks++;
    if (rise_cnt != 8) begin
      failures++;
      $display("FAIL single_sclk_count: got %0d required 8", rise_cnt);
    end
    checks++;
    if (per_min != 2 * CLK_DIV * T || per_max != 2 * CLK_DIV * T) begin
      failures++;
      $display("FAIL single_sclk_period: got min=%0t max=%0t required %0d", per_min, per_max, 2 * CLK_DIV * T);
    end
    checks++;
    if (ss_rise_t - last_fall_t != CS_HOLD * T) begin
      failures++;
      $display("FAIL single_cs_hold: got %0t required %0d", ss_rise_t - last_fall_t, CS_HOLD * T);
    end
  endtask

  task automatic test_back_to_back();
    int rx0;
    clear_mon();
    miso_loop = 1'b0;
    miso_pat  = 8'h5A;
    rx0       = rx_seen;
    send(8'h0E, 1'b0, 8'h5A, LAT_IDLE, 1'b1);
    send(8'h00, 1'b0, 8'h5A, LAT_WAIT, 1'b1);
    send(8'hFF, 1'b1, 8'h5A, LAT_WAIT, 1'b1);
    wait_idle("b2b");
    checks++;
    if (ss_rise_cnt != 1) begin
      failures++;
      $display("FAIL b2b_ss_n_rises: got %0d required 1", ss_rise_cnt);
    end
    checks++;
    if (rx_seen - rx0 != 3) begin
      failures++;
      $display("FAIL b2b_rx_count: got %0d required 3", rx_seen - rx0);
    end
    checks++;
    if (rise_cnt != 24) begin
      failures++;
      $display("FAIL b2b_sclk_count: got %0d required 24", rise_cnt);
    end
    miso_loop = 1'b1;
  endtask

  task automatic test_wait_stall();
    int n;
    int bad;
    clear_mon();
    miso_loop = 1'b1;
    send(8'h81, 1'b0, 8'h81, LAT_IDLE, 1'b1);
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (SCLK !== 1'b0 || SS_n !== 1'b0 || tx_ready !== 1'b1 || MOSI !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wait_stall: got %0d bad cycles of 20, required 0 (sclk=0 ss_n=0 ready=1 mosi=1)", bad);
    end
    send(8'h3E, 1'b1, 8'h3E, LAT_WAIT, 1'b1);
    wait_idle("wait");
    checks++;
    if (ss_rise_cnt != 1) begin
      failures++;
      $display("FAIL wait_ss_n_rises: got %0d required 1", ss_rise_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mon();
    miso_loop = 1'b1;
    send(8'hFF, 1'b1, 8'h00, LAT_IDLE, 1'b0);
    n = 0;
    @(negedge clk);
    while (rise_cnt < 4 && n < 200) begin
      n++;
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({SS_n, SCLK, MOSI, busy, rx_valid} !== 5'b10000 || rise_cnt != 4) begin
      failures++;
      $display("FAIL reset_mid: got ss_n/sclk/mosi/busy/rxv=%b rises=%0d required 10000 rises=4",
               {SS_n, SCLK, MOSI, busy, rx_valid}, rise_cnt);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    send(8'h3C, 1'b1, 8'h3C, LAT_IDLE, 1'b1);
    wait_idle("reset_mid");
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_sb: got %0d pending bytes required 0", sb.size());
    end
  endtask

  task automatic test_irq();
    clear_mon();
    miso_loop = 1'b1;
    send(8'h55, 1'b1, 8'h55, LAT_IDLE, 1'b1);
    nint = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall_early: got %b required 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL irq_assert: got irq=%b busy=%b required 1 1", irq, busy);
    end
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1 nint = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise_early: got %b required 1", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_deassert: got %b required 0", irq);
    end
    wait_idle("irq");
  endtask

  task automatic test_gap();
    int   n;
    int   bad;
    exp_t e;
    clear_mon();
    miso_loop = 1'b1;
    send(8'h11, 1'b1, 8'h11, LAT_IDLE, 1'b1);
    tx_data  = 8'h22;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    n   = 0;
    bad = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 500) begin
      if (busy !== 1'b1) bad++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0 || bad != 0) begin
      failures++;
      $display("FAIL gap_ready: got tx_ready=%b busy=%b early_idle=%0d required 1 0 0", tx_ready, busy, bad);
    end
    @(posedge clk);
    e.data = 8'h22;
    e.t    = $time + LAT_IDLE * T + T / 2;
    sb.push_back(e);
    #1 tx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (SS_n !== 1'b0 || ss_fall_t - ss_rise_t < CS_GAP * T) begin
      failures++;
      $display("FAIL gap_ss_n_high: got ss_n=%b high_for=%0t required 0 and >=%0d",
               SS_n, ss_fall_t - ss_rise_t, CS_GAP * T);
    end
    wait_idle("gap");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wait_stall();
    test_reset_mid();
    test_irq();
    test_gap();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending bytes required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(T * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
